// File: rtl/aes128_decrypt_iter_if.sv
// aes128_decrypt_iter_if: request/result bundle between a host and the AES-128 decrypt core
interface aes128_decrypt_iter_if;
  logic start;
  logic [127:0] ct_in;
  logic [127:0] key_in;
  logic busy;
  logic [127:0] pt_out;
  logic pt_valid;
  logic match_led;
  modport master(output start, ct_in, key_in, input busy, pt_out, pt_valid, match_led);
  modport slave(input start, ct_in, key_in, output busy, pt_out, pt_valid, match_led);
endinterface

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one inverse round per clock, key schedule run backwards on the fly
module aes128_decrypt_iter #(
  parameter logic [127:0] EXPECTED_PT = 128'h00112233445566778899aabbccddeeff
) (
  input logic clk,
  input logic rst,
  aes128_decrypt_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;
  localparam logic [31:0] IMC = 32'h0e0b0d09;
  state_t state;
  logic [127:0] st, rk, rk_fwd, rk_prev, t, mixed;
  logic [31:0] kw, rw, sw, kx;
  logic [7:0] rcon;
  logic [3:0] cnt;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254 by square-and-multiply; 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 7; k >= 0; k--) begin
      r = gmul(r, r);
      r = k != 0 ? gmul(r, a) : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox_f(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  // both tables fold to constant ROMs
  for (genvar i = 0; i < 256; i++) begin : g_tab
    assign sb[i] = sbox_f(8'(i));
    assign isb[i] = isbox_f(8'(i));
  end

  // one shared SubWord serves forward expansion (KEXP) and backward regeneration (ROUND)
  always_comb begin
    kw = state == KEXP ? rk[31:0] : rk[31:0] ^ rk[63:32];
    rw = {kw[23:0], kw[31:24]};
    sw = '0;
    for (int k = 0; k < 4; k++) sw[31-8*k -: 8] = sb[rw[31-8*k -: 8]];
    kx = sw ^ {rcon, 24'h0};
    rk_fwd = {rk[127:96] ^ kx,
              rk[127:96] ^ rk[95:64] ^ kx,
              rk[127:96] ^ rk[95:64] ^ rk[63:32] ^ kx,
              rk[127:96] ^ rk[95:64] ^ rk[63:32] ^ rk[31:0] ^ kx};
    rk_prev = {rk[127:96] ^ kx, rk[127:96] ^ rk[95:64], rk[95:64] ^ rk[63:32], rk[63:32] ^ rk[31:0]};
  end

  always_comb begin
    t = '0;
    mixed = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = isb[st[127-8*(4*((c-r+4)%4)+r) -: 8]] ^ rk_prev[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          mixed[127-8*(4*c+r) -: 8] = mixed[127-8*(4*c+r) -: 8] ^
            gmul(t[127-8*(4*c+k) -: 8], IMC[31-8*((k-r+4)%4) -: 8]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      st <= '0;
      rk <= '0;
      rcon <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.pt_out <= '0;
      bus.pt_valid <= 1'b0;
      bus.match_led <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE:
          if (bus.start) begin
            st <= bus.ct_in;
            rk <= bus.key_in;
            rcon <= 8'h01;
            cnt <= '0;
            bus.busy <= 1'b1;
            bus.pt_valid <= 1'b0;
            bus.match_led <= 1'b0;
            state <= KEXP;
          end
        KEXP: begin
          rk <= rk_fwd;
          cnt <= cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
          rcon <= cnt == 4'd9 ? 8'h36 : xtime(rcon);
          st <= cnt == 4'd9 ? st ^ rk_fwd : st;
          state <= cnt == 4'd9 ? ROUND : KEXP;
        end
        ROUND: begin
          st <= cnt == 4'd9 ? t : mixed;
          rk <= rk_prev;
          rcon <= rcon[0] ? ((rcon ^ 8'h1b) >> 1) | 8'h80 : rcon >> 1;
          cnt <= cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
          if (cnt == 4'd9) begin
            bus.pt_out <= t;
            bus.pt_valid <= 1'b1;
            bus.busy <= 1'b0;
            bus.match_led <= t == EXPECTED_PT;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: random round-trip and known-answer checks of the AES-128 decrypt core against an encryption model
module tb_aes128_decrypt_iter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  aes128_decrypt_iter_if bus();
  aes128_decrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  int checks = 0;
  int fails = 0;
  logic [7:0] sbox [256];
  logic [127:0] exp_pt = '0;
  logic m_busy, m_valid;
  logic [127:0] m_out, m_pt;
  int m_left;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? (a << 1) ^ 8'h1b : a << 1;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) u[b] = sbox[s[4*((b/4 + b%4) % 4) + b%4]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        s[4*c]   = r == 10 ? a0 : xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        s[4*c+1] = r == 10 ? a1 : a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        s[4*c+2] = r == 10 ? a2 : a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        s[4*c+3] = r == 10 ? a3 : xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      for (int b = 0; b < 16; b++) s[b] ^= w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // reference timing: an accepted block delivers its plaintext 20 edges later
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 1'b0;
      m_valid <= 1'b0;
      m_out <= '0;
      m_pt <= '0;
      m_left <= 0;
    end else if (!m_busy && bus.start) begin
      m_busy <= 1'b1;
      m_valid <= 1'b0;
      m_left <= 20;
      m_pt <= exp_pt;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_valid <= 1'b1;
        m_out <= m_pt;
      end
    end

  always @(negedge clk) begin
    check("busy", 128'(bus.busy), 128'(m_busy));
    check("pt_valid", 128'(bus.pt_valid), 128'(m_valid));
    check("pt_out", bus.pt_out, m_out);
    check("match_led", 128'(bus.match_led), 128'(m_valid && m_out == P1));
  end

  task automatic go(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    bus.key_in = k;
    bus.ct_in = c;
    exp_pt = p;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key_in = rnd();
    bus.ct_in = rnd();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pt_valid && n < 40);
  endtask

  initial begin
    logic [7:0] inv, sv, c63;
    logic [127:0] k, p;
    logic [127:0] pts [3];
    int n;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sbox[x] = sv;
    end
    bus.start = 1'b0;
    bus.ct_in = '0;
    bus.key_in = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_busy", 128'(bus.busy), 128'(0));
    check("reset_valid", 128'(bus.pt_valid), 128'(0));
    check("reset_pt", bus.pt_out, 128'(0));
    check("reset_led", 128'(bus.match_led), 128'(0));
    rst = 1'b0;
    check("model_c1", aes_enc(K1, P1), C1);
    check("model_appb", aes_enc(K2, P2), C2);
    go(K1, C1, P1);
    wait_valid(n);
    check("c1_latency", 128'(n), 128'(20));
    check("c1_pt", bus.pt_out, P1);
    check("c1_led", 128'(bus.match_led), 128'(1));
    go(K2, C2, P2);
    wait_valid(n);
    check("appb_pt", bus.pt_out, P2);
    check("appb_led", 128'(bus.match_led), 128'(0));
    // start pulses at E3 and E10 land while busy and must be ignored
    go(K1, C1, P1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(n);
    check("ignore_latency", 128'(n), 128'(10));
    check("ignore_pt", bus.pt_out, P1);
    repeat (3) @(negedge clk);
    check("ignore_idle", 128'({bus.busy, bus.pt_valid}), 128'(2'b01));
    go(K2, C2, P2);
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_valid", 128'(bus.pt_valid), 128'(0));
    check("abort_pt", bus.pt_out, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    go(K1, C1, P1);
    wait_valid(n);
    check("restart_latency", 128'(n), 128'(20));
    check("restart_pt", bus.pt_out, P1);
    for (int i = 0; i < 1000; i++) begin
      k = i == 0 ? '0 : i == 1 ? '1 : rnd();
      p = rnd();
      go(k, aes_enc(k, p), p);
      wait_valid(n);
      check("trip_pt", bus.pt_out, p);
    end
    for (int b = 0; b < 3; b++) pts[b] = rnd();
    k = rnd();
    bus.key_in = k;
    bus.ct_in = aes_enc(k, pts[0]);
    exp_pt = pts[0];
    bus.start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_valid(n);
      check("b2b_gap", 128'(n - 1), 128'(20));
      check("b2b_pt", bus.pt_out, pts[b]);
      if (b < 2) begin
        bus.ct_in = aes_enc(k, pts[b+1]);
        exp_pt = pts[b+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
